// File: rtl/xor_stream.sv
// Streaming XOR of a valid/ready word stream with a rolling multi-word key.
// The key loads word by word; the output stage is a single register slice.
module xor_stream #(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  logic              key_wr,
  input  logic [DATA_W-1:0] key_data,
  input  logic              key_clear,
  output logic              key_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PTR_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {
    KEY_EMPTY = 2'd0,
    KEY_LOAD  = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  wcnt_q, wcnt_d;
  logic [PTR_W-1:0]  kptr_q, kptr_d;
  logic [DATA_W-1:0] key_q [KEY_WORDS];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q;
  logic              accept;

  assign in_ready   = (state_q == RUN) && !key_clear && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign key_loaded = (state_q == RUN);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;

  always_comb begin
    kptr_d     = kptr_q;
    wcnt_d     = (wcnt_q == LAST_IDX) ? '0 : wcnt_q + PTR_W'(1);
    out_data_d = enabled ? (in_data ^ key_q[kptr_q]) : in_data;
    // Packet end restarts the key regardless of mode; bypass words do not advance it.
    if (in_last)
      kptr_d = '0;
    else if (enabled)
      kptr_d = (kptr_q == LAST_IDX) ? '0 : kptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= KEY_EMPTY;
      wcnt_q      <= '0;
      kptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
    end else begin
      if (key_clear) begin
        state_q <= KEY_EMPTY;
        wcnt_q  <= '0;
        kptr_q  <= '0;
        for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      end else if (key_wr) begin
        case (state_q)
          KEY_EMPTY, KEY_LOAD: begin
            key_q[wcnt_q] <= key_data;
            wcnt_q        <= wcnt_d;
            state_q       <= (wcnt_q == LAST_IDX) ? RUN : KEY_LOAD;
          end
          default: ;
        endcase
      end

      // accept implies RUN and no key_clear, so it never collides with key updates
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_last_q  <= in_last;
        kptr_q      <= kptr_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/xor_stream.md
# xor_stream

Streaming, parametrised successor to the combinational `xorer`. It XORs a valid/ready word stream with a multi-word rolling key held in an internal key register file. It adds per-packet key-pointer restart, a bypass mode and a registered output stage. It sits between a word source and sink in the data path and gives one word per cycle of throughput at one cycle of latency.

## Interface
- `DATA_W`, default 32: width of data and key words, in bits (≥1).
- `KEY_WORDS`, default 4: number of key words in the rolling key (≥1). Pointer width is `PTR_W = max(1, $clog2(KEY_WORDS))`.

- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `enabled`, input, 1: 1 = XOR mode, 0 = bypass. Sampled per accepted word.
- `key_wr`, input, 1: key write strobe.
- `key_data`, input, `DATA_W`: key word to write.
- `key_clear`, input, 1: discard the key and return to the empty state.
- `key_loaded`, output, 1: high when the full key is loaded (state RUN).
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: block can accept an input word.
- `in_data`, input, `DATA_W`: input word.
- `in_last`, input, 1: last word of a packet.
- `out_valid`, output, 1: output word valid.
- `out_ready`, input, 1: sink accepts the output word.
- `out_data`, output, `DATA_W`: output word.
- `out_last`, output, 1: copy of `in_last` for this word.

## Operation
- **States.**
  - KEY_EMPTY (reset state).
  - KEY_LOAD: a partial key has been written.
  - RUN: all `KEY_WORDS` key words are written.
- **Key write** (`key_wr=1`, `key_clear=0`, state is not RUN):
  - `key_data` is stored in `key[wcnt]` and `wcnt` increments.
  - The first write moves KEY_EMPTY to KEY_LOAD.
  - The write with `wcnt == KEY_WORDS-1` moves to RUN and resets `wcnt` to 0.
  - When `KEY_WORDS == 1`, KEY_EMPTY goes directly to RUN.
- **`key_wr` in RUN** is ignored. Reloading the key requires `key_clear` first.
- **`key_clear`** takes priority over `key_wr` in the same cycle. It:
  - sets the state to KEY_EMPTY;
  - zeroes `wcnt`, `kptr` and all key words.
  - A word already held in the output register stays valid and is still delivered.
- **Accept condition:** `in_valid && in_ready`, where `in_ready = (state==RUN) && !key_clear && (!out_valid || out_ready)`. `in_ready` is combinational.
- **On accept:**
  - `enabled=1`: `out_data <= in_data ^ key[kptr]`. `kptr` increments and wraps from `KEY_WORDS-1` to 0.
  - `enabled=0`: `out_data <= in_data` and `kptr` holds.
  - In both modes `out_last <= in_last`.
  - If `in_last=1`, `kptr <= 0` (overrides the increment) in either mode.
- **Output register:**
  - `out_valid` sets on accept.
  - `out_valid` clears when `out_ready && out_valid` with no accept in the same cycle.
  - A simultaneous drain and accept keeps `out_valid=1` and loads the new word.
- **Stall:** while `out_valid && !out_ready`, `out_data` and `out_last` are held stable and `in_ready=0`.
- **Arithmetic:** bitwise XOR at full `DATA_W`, with no truncation or extension.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `key_loaded=0`, `in_ready=0`.
  - `kptr=0`, `wcnt=0`, all key words 0, state KEY_EMPTY.
- **Reset mid-operation:** a pending output word is dropped.
- **Latency:**
  - Accepted at edge N, the word appears with `out_valid=1` after edge N.
  - With `out_ready` held high, throughput is one word per cycle.
- **Key load:** `key_loaded` rises the cycle after the final `key_wr` edge. `in_ready` can be high from that cycle.
- **`key_clear`:** `in_ready` is forced low in the `key_clear` cycle itself. `key_loaded` falls after that edge.
- **Pointer wrap:** word index `i` within a packet uses `key[i mod KEY_WORDS]`, counting XOR-mode words only.

## Test plan
1. **Single-key XOR.** `KEY_WORDS=1`. Load key `0x00000001`. Send `0xFFFFFFFF` with `enabled=1`, `in_last=1` → one cycle later `out_data=0xFFFFFFFE`, `out_last=1`.
2. **Rolling key with wrap.** `KEY_WORDS=4`. Load keys `0x1, 0x2, 0x4, 0x8`. Stream six words of `0x0` with `out_ready=1`, last word tagged → outputs are `0x1, 0x2, 0x4, 0x8, 0x1, 0x2`. The next packet's first word is XORed with `0x1`.
3. **Bypass.** Toggle `enabled=0` for the 2nd of three `0xA5A5A5A5` words, keys as in test 2 → outputs are `0xA5A5A5A4, 0xA5A5A5A5, 0xA5A5A5A7`.
4. **Back-pressure.** Hold `out_ready=0` for 3 cycles with one word pending → `in_ready=0`, and `out_data`/`out_last` stay stable. On release, no word is lost or duplicated.
5. **Key lifecycle.**
   - `in_valid=1` before the key is loaded → `in_ready=0`.
   - `key_wr` in RUN → key unchanged.
   - `key_clear` together with `key_wr` → state KEY_EMPTY, `key_loaded=0`, key words 0.
6. **Reset mid-stream.** Assert `rst` while `out_valid=1` → the next cycle has all outputs at their reset values. The key must then be reloaded before `in_ready` rises.
